// File: rtl/terminal_line_reader.sv
// terminal_line_reader
//
// Purpose:
//   Read side of the terminal text-grid buffer. On a start request it walks
//   one screen row through the buffer's read port, one character per read,
//   and streams the characters over a valid/ready interface. Every line is
//   terminated by a newline byte (10) flagged with last_out. A newline read
//   from the buffer ends the line early. A row with no newline is closed
//   with a synthetic newline once all of its columns have been sent.
//
// Optional feature (macro SPACE_COLLAPSE_EN):
//   When defined, a space (32) read immediately after an emitted space in
//   the same line is dropped without a handshake. This means runs of spaces,
//   including leading ones, collapse to a single space. When undefined,
//   every byte read is emitted verbatim.
//
// Ports:
//   pixel_clk_in    clock
//   rst_in          synchronous active-high reset
//   start_in        one-cycle request to read a row
//   start_row_in    row to read, sampled with start_in
//   busy_out        high while a line is being processed
//   tg_re           one-cycle read strobe to the buffer
//   tg_addr         buffer read address (row*SCREEN_WIDTH + col)
//   tg_data_in      byte returned by the buffer READ_LATENCY cycles later
//   char_out        streamed ASCII byte
//   char_valid_out  char_out valid
//   char_ready_in   downstream accepts the byte when high with valid
//   last_out        marks the terminating newline byte

module terminal_line_reader #(
  parameter int SCREEN_WIDTH  = 76,
  parameter int SCREEN_HEIGHT = 44,
  parameter int READ_LATENCY  = 2
) (
  input  logic                                          pixel_clk_in,
  input  logic                                          rst_in,
  input  logic                                          start_in,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0]              start_row_in,
  output logic                                          busy_out,
  output logic                                          tg_re,
  output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] tg_addr,
  input  logic [7:0]                                    tg_data_in,
  output logic [7:0]                                    char_out,
  output logic                                          char_valid_out,
  input  logic                                          char_ready_in,
  output logic                                          last_out
);

  localparam int ROW_W  = $clog2(SCREEN_HEIGHT);
  localparam int ADDR_W = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT);
  localparam int COL_W  = $clog2(SCREEN_WIDTH+1);
  localparam int WAIT_W = $clog2(READ_LATENCY+1);

  localparam logic [7:0]       NEWLINE  = 8'd10;
  localparam logic [7:0]       SPACE    = 8'd32;
  localparam logic [ROW_W:0]   HEIGHT_L = (ROW_W+1)'(SCREEN_HEIGHT);
  localparam logic [COL_W-1:0] WIDTH_L  = COL_W'(SCREEN_WIDTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_FLUSH
  } state_t;

  state_t              state, state_next;
  logic [ROW_W-1:0]    row, row_next;
  logic [COL_W-1:0]    col, col_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next;
  logic                tg_re_next;
  logic [ADDR_W-1:0]   tg_addr_next;
  logic [7:0]          char_next;
  logic                valid_next;
  logic                last_next;

  logic [ADDR_W-1:0]   issue_addr;
  logic                row_ok;
  logic                col_at_end;
  logic                wait_done;
  logic                drop_byte;

  // Full-width address: row and column are widened before the multiply so
  // the largest address (last column of the last row) is never truncated.
  assign issue_addr = ADDR_W'(row) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(col);
  assign row_ok     = {1'b0, start_row_in} < HEIGHT_L;
  assign col_at_end = (col + 1'b1) == WIDTH_L;

  // The address register loads when ISSUE is left; the wait counter then
  // starts at zero, so the data is sampled READ_LATENCY edges after that.
  assign wait_done  = wait_cnt == WAIT_LAST;
  assign busy_out   = state != S_IDLE;

`ifdef SPACE_COLLAPSE_EN
  logic prev_space;

  // Remembers whether the last byte handed downstream in this line was a
  // space; cleared whenever the block is idle so every line starts fresh.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      prev_space <= 1'b0;
    end else if (state == S_IDLE) begin
      prev_space <= 1'b0;
    end else if (state == S_WAIT && wait_done && !drop_byte) begin
      prev_space <= tg_data_in == SPACE;
    end
  end

  assign drop_byte = prev_space && (tg_data_in == SPACE);
`else
  assign drop_byte = 1'b0;
`endif

  // Next-state and next-output logic. Every output is registered, so this
  // block computes the register inputs, which default to holding their
  // values, with tg_re defaulting low so the read strobe is one cycle wide.
  always_comb begin
    state_next    = state;
    row_next      = row;
    col_next      = col;
    wait_cnt_next = wait_cnt;
    tg_re_next    = 1'b0;
    tg_addr_next  = tg_addr;
    char_next     = char_out;
    valid_next    = char_valid_out;
    last_next     = last_out;

    unique case (state)
      S_IDLE: begin
        if (start_in && row_ok) begin
          row_next   = start_row_in;
          col_next   = '0;
          state_next = S_ISSUE;
        end
      end

      S_ISSUE: begin
        tg_re_next    = 1'b1;
        tg_addr_next  = issue_addr;
        wait_cnt_next = '0;
        state_next    = S_WAIT;
      end

      S_WAIT: begin
        if (!wait_done) begin
          wait_cnt_next = wait_cnt + 1'b1;
        end else if (drop_byte) begin
          // Collapsed space: move on to the next column with no handshake.
          col_next = col + 1'b1;
          if (col_at_end) begin
            char_next  = NEWLINE;
            last_next  = 1'b1;
            valid_next = 1'b1;
            state_next = S_FLUSH;
          end else begin
            state_next = S_ISSUE;
          end
        end else begin
          char_next  = tg_data_in;
          last_next  = tg_data_in == NEWLINE;
          valid_next = 1'b1;
          state_next = S_OUT;
        end
      end

      S_OUT: begin
        if (char_ready_in) begin
          if (last_out) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
            state_next = S_IDLE;
          end else begin
            col_next = col + 1'b1;
            if (col_at_end) begin
              // Row exhausted without a newline: close it synthetically.
              char_next  = NEWLINE;
              last_next  = 1'b1;
              valid_next = 1'b1;
              state_next = S_FLUSH;
            end else begin
              valid_next = 1'b0;
              state_next = S_ISSUE;
            end
          end
        end
      end

      S_FLUSH: begin
        if (char_ready_in) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset returns to IDLE and drops any read
  // still in flight; its returning byte is never sampled.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      row            <= '0;
      col            <= '0;
      wait_cnt       <= '0;
      tg_re          <= 1'b0;
      tg_addr        <= '0;
      char_out       <= '0;
      char_valid_out <= 1'b0;
      last_out       <= 1'b0;
    end else begin
      state          <= state_next;
      row            <= row_next;
      col            <= col_next;
      wait_cnt       <= wait_cnt_next;
      tg_re          <= tg_re_next;
      tg_addr        <= tg_addr_next;
      char_out       <= char_next;
      char_valid_out <= valid_next;
      last_out       <= last_next;
    end
  end

endmodule

// File: tb/tb_terminal_line_reader.sv
// tb_terminal_line_reader
//
// Bench for terminal_line_reader. A behavioural buffer model answers reads
// with the DUT's read latency. Rows are described by a table of records;
// for each one the expected read addresses and output bytes are derived
// from the buffer contents and queued, then popped as the DUT produces
// them. Hand-written sequences cover reset, start latency, ignored starts
// and reset during an outstanding read. Honours SPACE_COLLAPSE_EN.

module tb_terminal_line_reader;

  localparam int W      = 76;
  localparam int H      = 44;
  localparam int RL     = 2;
  localparam int ROW_W  = $clog2(H);
  localparam int ADDR_W = $clog2(W*H);

`ifdef SPACE_COLLAPSE_EN
  localparam bit COLLAPSE = 1'b1;
`else
  localparam bit COLLAPSE = 1'b0;
`endif

  logic              pixel_clk_in = 1'b0;
  logic              rst_in       = 1'b1;
  logic              start_in     = 1'b0;
  logic [ROW_W-1:0]  start_row_in = '0;
  logic              busy_out;
  logic              tg_re;
  logic [ADDR_W-1:0] tg_addr;
  logic [7:0]        tg_data_in;
  logic [7:0]        char_out;
  logic              char_valid_out;
  logic              char_ready_in = 1'b1;
  logic              last_out;

  terminal_line_reader #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .READ_LATENCY (RL)
  ) dut (
    .pixel_clk_in  (pixel_clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .start_row_in  (start_row_in),
    .busy_out      (busy_out),
    .tg_re         (tg_re),
    .tg_addr       (tg_addr),
    .tg_data_in    (tg_data_in),
    .char_out      (char_out),
    .char_valid_out(char_valid_out),
    .char_ready_in (char_ready_in),
    .last_out      (last_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  // Buffer model: one register stage after the DUT's registered address,
  // so the byte is on tg_data_in at the edge READ_LATENCY after issue.
  logic [7:0] mem [0:W*H-1];
  logic [7:0] bram_q;
  always @(posedge pixel_clk_in) bram_q <= mem[tg_addr];
  assign tg_data_in = bram_q;

  typedef struct {
    int          row;
    logic [63:0] text;
    int          n;
    logic [7:0]  fill;
    int          stall;
    bit          rnd;
    bit          mid;
    int          exp_n;
  } vec_t;

  logic [ADDR_W-1:0] addr_q[$];
  logic [8:0]        exp_q[$];

  int         checks = 0;
  int         errors = 0;
  int         out_count = 0;
  int         stall_left = 0;
  bit         rnd_ready = 1'b0;
  bit         prev_valid = 1'b0;
  bit         prev_ready = 1'b0;
  logic [7:0] prev_char = '0;
  logic       prev_last = 1'b0;
  bit         last_seen = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor, called once per cycle away from the active edge.
  task automatic sample_outputs();
    logic [8:0] e;
    if (tg_re === 1'b1) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_read: got tg_addr %0d, expected no read", tg_addr);
      end else begin
        checkOutput("tg_addr", 32'(tg_addr), 32'(addr_q.pop_front()));
      end
      checkOutput("no_read_while_valid", 32'(char_valid_out), 32'(0));
    end
    if (prev_valid && !prev_ready) begin
      checkOutput("stall_valid", 32'(char_valid_out), 32'(1));
      checkOutput("stall_char", 32'(char_out), 32'(prev_char));
      checkOutput("stall_last", 32'(last_out), 32'(prev_last));
    end
    if (char_valid_out === 1'b1 && char_ready_in === 1'b1) begin
      out_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_byte: got %0d, expected no output", char_out);
      end else begin
        e = exp_q.pop_front();
        checkOutput("char_out", 32'(char_out), 32'(e[7:0]));
        checkOutput("last_out", 32'(last_out), 32'(e[8]));
      end
      if (last_out === 1'b1) last_seen = 1'b1;
    end
    prev_valid = (char_valid_out === 1'b1);
    prev_ready = (char_ready_in === 1'b1);
    prev_char  = char_out;
    prev_last  = last_out;
  endtask

  // One clock: monitor at the falling edge, then drive just after the
  // rising edge.
  task automatic step_cycle();
    @(negedge pixel_clk_in);
    sample_outputs();
    @(posedge pixel_clk_in);
    #1;
    if (last_seen) begin
      last_seen = 1'b0;
      checkOutput("busy_after_last", 32'(busy_out), 32'(0));
    end
    if (char_valid_out === 1'b1 && stall_left > 0) begin
      char_ready_in = 1'b0;
      stall_left--;
    end else if (rnd_ready) begin
      char_ready_in = 1'($urandom_range(0, 1));
    end else begin
      char_ready_in = 1'b1;
    end
  endtask

  task automatic applyStimulus(input int row);
    start_row_in = ROW_W'(row);
    start_in     = 1'b1;
    step_cycle();
    start_in     = 1'b0;
  endtask

  task automatic load_row(input int row, input logic [63:0] text, input int n, input logic [7:0] fill);
    for (int c = 0; c < W; c++) begin
      if (c < n) mem[row*W+c] = text[8*c +: 8];
      else       mem[row*W+c] = fill;
    end
  endtask

  // Reference model of one line: every column is read in order until a
  // newline; with collapsing, a space after an emitted space is read but
  // not emitted; a row without a newline gets a trailing newline.
  task automatic load_expected(input int row);
    bit         prev;
    logic [7:0] b;
    prev = 1'b0;
    addr_q.delete();
    exp_q.delete();
    for (int c = 0; c < W; c++) begin
      addr_q.push_back(ADDR_W'(row*W + c));
      b = mem[row*W + c];
      if (b == 8'd10) begin
        exp_q.push_back({1'b1, 8'd10});
        return;
      end
      if (!(COLLAPSE && b == 8'd32 && prev)) begin
        exp_q.push_back({1'b0, b});
        prev = (b == 8'd32);
      end
    end
    exp_q.push_back({1'b1, 8'd10});
  endtask

  task automatic wait_idle(input string name, input int exp_n);
    int cyc;
    cyc = 0;
    while (busy_out && cyc < 2000) begin
      step_cycle();
      cyc++;
    end
    checkOutput({name, "_done"}, 32'(busy_out), 32'(0));
    checkOutput({name, "_bytes"}, 32'(out_count), 32'(exp_n));
    checkOutput({name, "_exp_left"}, 32'(exp_q.size()), 32'(0));
    checkOutput({name, "_addr_left"}, 32'(addr_q.size()), 32'(0));
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int cyc;
    load_row(v.row, v.text, v.n, v.fill);
    load_expected(v.row);
    out_count  = 0;
    stall_left = v.stall;
    rnd_ready  = v.rnd;
    applyStimulus(v.row);
    cyc = 0;
    while (busy_out && cyc < 2000) begin
      if (v.mid && cyc == 10) begin
        start_in     = 1'b1;
        start_row_in = ROW_W'(7);
      end
      step_cycle();
      start_in = 1'b0;
      cyc++;
    end
    rnd_ready = 1'b0;
    checkOutput($sformatf("vec%0d_done", idx), 32'(busy_out), 32'(0));
    checkOutput($sformatf("vec%0d_bytes", idx), 32'(out_count), 32'(v.exp_n));
    checkOutput($sformatf("vec%0d_exp_left", idx), 32'(exp_q.size()), 32'(0));
    checkOutput($sformatf("vec%0d_addr_left", idx), 32'(addr_q.size()), 32'(0));
  endtask

  localparam int EXP_MULTI_SP   = COLLAPSE ? 4 : 6;
  localparam int EXP_LEAD_SP    = COLLAPSE ? 3 : 4;
  localparam int EXP_ALL_SPACES = COLLAPSE ? 2 : 77;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{row: 0,  text: 64'({8'd10, 8'd98, 8'd97}), n: 3, fill: 8'd113,
                stall: 0, rnd: 1'b0, mid: 1'b0, exp_n: 3};
    vecs[1] = '{row: 43, text: 64'(0), n: 0, fill: 8'd120,
                stall: 0, rnd: 1'b0, mid: 1'b0, exp_n: 77};
    vecs[2] = '{row: 5,  text: 64'({8'd10, 8'd120}), n: 2, fill: 8'd113,
                stall: 5, rnd: 1'b0, mid: 1'b0, exp_n: 2};
    vecs[3] = '{row: 30, text: 64'({8'd10, 8'd102, 8'd101, 8'd100, 8'd99, 8'd98, 8'd97}), n: 7,
                fill: 8'd113, stall: 0, rnd: 1'b0, mid: 1'b1, exp_n: 7};
    vecs[4] = '{row: 2,  text: 64'({8'd10, 8'd100, 8'd99}), n: 3, fill: 8'd113,
                stall: 0, rnd: 1'b0, mid: 1'b0, exp_n: 3};
    vecs[5] = '{row: 12, text: 64'({8'd10, 8'd98, 8'd32, 8'd32, 8'd32, 8'd97}), n: 6,
                fill: 8'd113, stall: 0, rnd: 1'b0, mid: 1'b0, exp_n: EXP_MULTI_SP};
    vecs[6] = '{row: 1,  text: 64'(0), n: 0, fill: 8'd10,
                stall: 0, rnd: 1'b0, mid: 1'b0, exp_n: 1};
    vecs[7] = '{row: 20, text: 64'({8'd10, 8'd111, 8'd108, 8'd108, 8'd101, 8'd104}), n: 6,
                fill: 8'd113, stall: 0, rnd: 1'b1, mid: 1'b0, exp_n: 6};
    vecs[8] = '{row: 40, text: 64'({8'd10, 8'd122, 8'd32, 8'd32}), n: 4, fill: 8'd113,
                stall: 0, rnd: 1'b0, mid: 1'b0, exp_n: EXP_LEAD_SP};
    vecs[9] = '{row: 3,  text: 64'(0), n: 0, fill: 8'd32,
                stall: 0, rnd: 1'b0, mid: 1'b0, exp_n: EXP_ALL_SPACES};

    for (int i = 0; i < W*H; i++) mem[i] = 8'd113;

    // Reset values.
    rst_in = 1'b1;
    repeat (3) step_cycle();
    checkOutput("rst_busy", 32'(busy_out), 32'(0));
    checkOutput("rst_tg_re", 32'(tg_re), 32'(0));
    checkOutput("rst_valid", 32'(char_valid_out), 32'(0));
    checkOutput("rst_last", 32'(last_out), 32'(0));
    checkOutput("rst_tg_addr", 32'(tg_addr), 32'(0));
    checkOutput("rst_char", 32'(char_out), 32'(0));
    rst_in = 1'b0;
    step_cycle();

    // Start-to-output latency on row 0 ("ab" + newline).
    $display("[TB] latency sequence");
    load_row(0, 64'({8'd10, 8'd98, 8'd97}), 3, 8'd113);
    load_expected(0);
    out_count = 0;
    applyStimulus(0);
    checkOutput("lat_busy_k", 32'(busy_out), 32'(1));
    checkOutput("lat_re_k", 32'(tg_re), 32'(0));
    step_cycle();
    checkOutput("lat_re_k1", 32'(tg_re), 32'(1));
    checkOutput("lat_addr_k1", 32'(tg_addr), 32'(0));
    step_cycle();
    checkOutput("lat_re_k2", 32'(tg_re), 32'(0));
    checkOutput("lat_valid_k2", 32'(char_valid_out), 32'(0));
    step_cycle();
    checkOutput("lat_valid_k3", 32'(char_valid_out), 32'(1));
    checkOutput("lat_char_k3", 32'(char_out), 32'(97));
    wait_idle("lat", 3);

    // Out-of-range row is ignored.
    $display("[TB] out-of-range start sequence");
    addr_q.delete();
    exp_q.delete();
    applyStimulus(44);
    for (int i = 0; i < 10; i++) begin
      checkOutput("row44_busy", 32'(busy_out), 32'(0));
      step_cycle();
    end

    // Reset while a read is outstanding on row 2.
    $display("[TB] reset during wait sequence");
    load_row(2, 64'({8'd10, 8'd100, 8'd99}), 3, 8'd113);
    addr_q.delete();
    exp_q.delete();
    addr_q.push_back(ADDR_W'(152));
    applyStimulus(2);
    step_cycle();
    rst_in = 1'b1;
    step_cycle();
    rst_in = 1'b0;
    checkOutput("rstw_busy", 32'(busy_out), 32'(0));
    checkOutput("rstw_valid", 32'(char_valid_out), 32'(0));
    checkOutput("rstw_tg_re", 32'(tg_re), 32'(0));
    repeat (6) step_cycle();
    checkOutput("rstw_busy_later", 32'(busy_out), 32'(0));
    checkOutput("rstw_addr_left", 32'(addr_q.size()), 32'(0));

    // Table-driven rows.
    for (int i = 0; i < 10; i++) begin
      $display("[TB] vector %0d row %0d", i, vecs[i].row);
      run_vector(i, vecs[i]);
      repeat (2) step_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
